// File: rtl/cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_if
// Description : CPU, main-memory and line-SRAM signals of the cache controller.
// Revision    : 1.0
// ============================================================================
interface cache_ctrl_if;
    logic [31:0]  phy_addr;
    logic [31:0]  data_from_cpu;
    logic         read_mem;
    logic         write_mem;
    logic [31:0]  data_to_cpu;
    logic         hit_miss;
    logic         ready_stall;
    logic [5:0]   cache_mem_index;
    logic [511:0] cache_mem_data_in;
    logic         cache_mem_write_en;
    logic [511:0] cache_mem_data_out;
    logic [31:0]  main_mem_addr;
    logic [31:0]  main_mem_data_out;
    logic         main_mem_read_req;
    logic         main_mem_write_req;
    logic [511:0] main_mem_data_in;
    logic         main_mem_ready;

    // The controller side.
    modport slave (
        input  phy_addr, data_from_cpu, read_mem, write_mem,
        input  cache_mem_data_out, main_mem_data_in, main_mem_ready,
        output data_to_cpu, hit_miss, ready_stall,
        output cache_mem_index, cache_mem_data_in, cache_mem_write_en,
        output main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req
    );

    // The CPU, main memory and SRAM side.
    modport master (
        output phy_addr, data_from_cpu, read_mem, write_mem,
        output cache_mem_data_out, main_mem_data_in, main_mem_ready,
        input  data_to_cpu, hit_miss, ready_stall,
        input  cache_mem_index, cache_mem_data_in, cache_mem_write_en,
        input  main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req
    );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl
// Description : 2-way set-associative write-through, no-write-allocate cache
//               controller; line data held in an external SRAM.
// Revision    : 1.0
// ============================================================================
module cache_ctrl (
    input  wire logic    clk,
    input  wire logic    rst,
    cache_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        FILL      = 3'd4,
        FILL_DONE = 3'd5,
        WR_REQ    = 3'd6,
        WR_WAIT   = 3'd7
    } state_t;

    state_t        r_state;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_is_write;
    logic [19:0]   r_tag [2][64];
    logic [63:0]   r_valid [2];
    logic          lru_store [0:63];

    logic [31:0]   r_data_to_cpu;
    logic          r_hit_miss;
    logic          r_ready_stall;
    logic [511:0]  r_cm_din;
    logic          r_cm_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_rd_req;
    logic          r_wr_req;

    logic [5:0]    w_idx;
    logic [19:0]   w_tag;
    logic [8:0]    w_word_lsb;
    logic          w_victim;
    logic          way0_hit;
    logic          way1_hit;
    logic          w_hit;

    assign w_idx      = r_addr[11:6];
    assign w_tag      = r_addr[31:12];
    assign w_word_lsb = {r_addr[5:2], 5'd0};
    assign w_victim   = lru_store[w_idx];
    assign way0_hit   = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign way1_hit   = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit      = way0_hit || way1_hit;

    assign bus.data_to_cpu        = r_data_to_cpu;
    assign bus.hit_miss           = r_hit_miss;
    assign bus.ready_stall        = r_ready_stall;
    assign bus.cache_mem_index    = (r_state == IDLE) ? bus.phy_addr[11:6] : w_idx;
    assign bus.cache_mem_data_in  = r_cm_din;
    assign bus.cache_mem_write_en = r_cm_we;
    assign bus.main_mem_addr      = r_mem_addr;
    assign bus.main_mem_data_out  = r_mem_wdata;
    assign bus.main_mem_read_req  = r_rd_req;
    assign bus.main_mem_write_req = r_wr_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_is_write    <= 1'b0;
            r_valid[0]    <= '0;
            r_valid[1]    <= '0;
            for (int i = 0; i < 64; i++) begin
                lru_store[i] <= 1'b0;
            end
            r_data_to_cpu <= '0;
            r_hit_miss    <= 1'b0;
            r_ready_stall <= 1'b0;
            r_cm_din      <= '0;
            r_cm_we       <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_rd_req      <= 1'b0;
            r_wr_req      <= 1'b0;
        end else begin
            // Request strobes are single-cycle; only the REQ/FILL entries raise them.
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_cm_we  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.write_mem || bus.read_mem) begin
                        r_addr        <= bus.phy_addr;
                        r_wdata       <= bus.data_from_cpu;
                        r_is_write    <= bus.write_mem;
                        r_ready_stall <= 1'b1;
                        r_state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (r_is_write) begin
                        r_hit_miss <= w_hit;
                        if (way0_hit) r_valid[0][w_idx] <= 1'b0;
                        if (way1_hit) r_valid[1][w_idx] <= 1'b0;
                        r_wr_req    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                        r_state     <= WR_REQ;
                    end else if (w_hit) begin
                        r_hit_miss       <= 1'b1;
                        r_data_to_cpu    <= bus.cache_mem_data_out[w_word_lsb +: 32];
                        lru_store[w_idx] <= way0_hit;
                        r_ready_stall    <= 1'b0;
                        r_state          <= IDLE;
                    end else begin
                        r_hit_miss <= 1'b0;
                        r_rd_req   <= 1'b1;
                        r_mem_addr <= {w_tag, w_idx, 6'b0};
                        r_state    <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    r_state <= MISS_WAIT;
                end
                MISS_WAIT: begin
                    if (bus.main_mem_ready) begin
                        r_cm_din <= bus.main_mem_data_in;
                        r_cm_we  <= 1'b1;
                        r_state  <= FILL;
                    end
                end
                FILL: begin
                    // The SRAM writes the way named by lru_store, so it must stay put here.
                    r_tag[w_victim][w_idx]   <= w_tag;
                    r_valid[w_victim][w_idx] <= 1'b1;
                    r_state                  <= FILL_DONE;
                end
                FILL_DONE: begin
                    lru_store[w_idx] <= ~w_victim;
                    r_data_to_cpu    <= r_cm_din[w_word_lsb +: 32];
                    r_ready_stall    <= 1'b0;
                    r_state          <= IDLE;
                end
                WR_REQ: begin
                    r_state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (bus.main_mem_ready) begin
                        r_ready_stall <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl
// Description : Directed self-checking bench for cache_ctrl with a
//               transaction-level cache model, memory responder and SRAM model.
// Revision    : 1.0
// ============================================================================
module tb_cache_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_if bus_if ();
    cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

    int checks   = 0;
    int failures = 0;

    logic [511:0] sram [64][2];
    int           lat = 3;
    int           n_rd, n_wr, n_sw;
    logic [31:0]  rd_addr, wr_addr, wr_data;
    logic [5:0]   sw_idx;
    logic         sw_way;
    logic [511:0] sw_line;
    bit           mon_on = 1'b0;

    // Transaction-level cache state: tags, valids, victim way per set.
    bit           mv [2][64];
    logic [19:0]  mt [2][64];
    bit           ml [64];

    function automatic logic [511:0] mem_line(input logic [25:0] ln);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = {w[7:0], ln[23:0]};
        return l;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // External SRAM: way chosen by the controller's hit and LRU state.
    assign bus_if.cache_mem_data_out = sram[bus_if.cache_mem_index][dut.way1_hit];
    always @(posedge clk) begin
        if (bus_if.cache_mem_write_en === 1'b1)
            sram[bus_if.cache_mem_index][dut.lru_store[bus_if.cache_mem_index]] <= bus_if.cache_mem_data_in;
    end

    // Main memory responder.
    initial begin
        bit          was_rd;
        logic [31:0] ra;
        bus_if.main_mem_ready   = 1'b0;
        bus_if.main_mem_data_in = '0;
        forever begin
            @(negedge clk);
            if (bus_if.main_mem_read_req === 1'b1 || bus_if.main_mem_write_req === 1'b1) begin
                was_rd = bus_if.main_mem_read_req;
                ra     = bus_if.main_mem_addr;
                repeat (lat) @(negedge clk);
                bus_if.main_mem_data_in = was_rd ? mem_line(ra[31:6]) : '0;
                bus_if.main_mem_ready   = 1'b1;
                @(negedge clk);
                bus_if.main_mem_ready   = 1'b0;
                bus_if.main_mem_data_in = '0;
            end
        end
    end

    // Request logging plus per-cycle idle checks.
    always @(negedge clk) begin
        if (bus_if.main_mem_read_req === 1'b1) begin
            n_rd++;
            rd_addr = bus_if.main_mem_addr;
        end
        if (bus_if.main_mem_write_req === 1'b1) begin
            n_wr++;
            wr_addr = bus_if.main_mem_addr;
            wr_data = bus_if.main_mem_data_out;
        end
        if (bus_if.cache_mem_write_en === 1'b1) begin
            n_sw++;
            sw_idx  = bus_if.cache_mem_index;
            sw_way  = dut.lru_store[bus_if.cache_mem_index];
            sw_line = bus_if.cache_mem_data_in;
        end
        if (mon_on && !rst && bus_if.ready_stall === 1'b0) begin
            chk("idle_index", {26'd0, bus_if.cache_mem_index}, {26'd0, bus_if.phy_addr[11:6]});
            chk("idle_strobes", {29'd0, bus_if.main_mem_read_req, bus_if.main_mem_write_req,
                                 bus_if.cache_mem_write_en}, 32'd0);
        end
    end

    task automatic check_zero();
        chk("z_data_to_cpu", bus_if.data_to_cpu, 32'd0);
        chk("z_hit_miss", {31'd0, bus_if.hit_miss}, 32'd0);
        chk("z_ready_stall", {31'd0, bus_if.ready_stall}, 32'd0);
        chk("z_mem_addr", bus_if.main_mem_addr, 32'd0);
        chk("z_mem_data_out", bus_if.main_mem_data_out, 32'd0);
        chk("z_strobes", {29'd0, bus_if.main_mem_read_req, bus_if.main_mem_write_req,
                          bus_if.cache_mem_write_en}, 32'd0);
        chk("z_cm_data_in", {31'd0, |bus_if.cache_mem_data_in}, 32'd0);
        chk("z_cm_index", {26'd0, bus_if.cache_mem_index}, 32'd0);
    endtask

    task automatic model_clear();
        for (int s = 0; s < 64; s++) begin
            mv[0][s] = 1'b0;
            mv[1][s] = 1'b0;
            ml[s]    = 1'b0;
        end
    endtask

    task automatic do_op(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input bit poke);
        logic [5:0]   idx;
        logic [19:0]  tg;
        bit           h0, h1, hit, exp_way, fill;
        logic [511:0] line;
        logic [31:0]  exp_data;
        int           cyc;
        idx      = a[11:6];
        tg       = a[31:12];
        h0       = mv[0][idx] && (mt[0][idx] == tg);
        h1       = mv[1][idx] && (mt[1][idx] == tg);
        hit      = h0 || h1;
        line     = mem_line(a[31:6]);
        exp_data = line[a[5:2]*32 +: 32];
        exp_way  = ml[idx];
        fill     = !wr && !hit;
        if (wr) begin
            if (h0) mv[0][idx] = 1'b0;
            if (h1) mv[1][idx] = 1'b0;
        end else if (hit) begin
            ml[idx] = h0;
        end else begin
            mt[exp_way][idx] = tg;
            mv[exp_way][idx] = 1'b1;
            ml[idx]          = !exp_way;
        end

        @(negedge clk);
        n_rd = 0; n_wr = 0; n_sw = 0;
        bus_if.phy_addr      = a;
        bus_if.data_from_cpu = d;
        bus_if.write_mem     = wr;
        bus_if.read_mem      = rd;
        @(posedge clk); #1;
        bus_if.write_mem = 1'b0;
        bus_if.read_mem  = 1'b0;
        chk("accept_busy", {31'd0, bus_if.ready_stall}, 32'd1);
        @(posedge clk); #1;
        chk("hit_miss", {31'd0, bus_if.hit_miss}, {31'd0, hit});
        if (!wr && hit) begin
            chk("hit_ready", {31'd0, bus_if.ready_stall}, 32'd0);
            chk("hit_data", bus_if.data_to_cpu, exp_data);
        end
        if (poke && !(!wr && hit)) begin
            @(negedge clk);
            bus_if.read_mem  = 1'b1;
            bus_if.write_mem = 1'b1;
            bus_if.phy_addr  = a ^ 32'h40;
            @(negedge clk);
            bus_if.read_mem  = 1'b0;
            bus_if.write_mem = 1'b0;
        end
        cyc = 0;
        while (bus_if.ready_stall !== 1'b0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_in_budget", {31'd0, bus_if.ready_stall}, 32'd0);
        @(negedge clk);
        chk("n_read_req", n_rd, {31'd0, fill});
        chk("n_write_req", n_wr, {31'd0, wr});
        chk("n_sram_write", n_sw, {31'd0, fill});
        if (fill) begin
            chk("read_req_addr", rd_addr, {a[31:6], 6'b0});
            chk("sram_wr_index", {26'd0, sw_idx}, {26'd0, idx});
            chk("sram_wr_way", {31'd0, sw_way}, {31'd0, exp_way});
            chk("sram_wr_line", {31'd0, sw_line == line}, 32'd1);
        end
        if (wr) begin
            chk("write_req_addr", wr_addr, a);
            chk("write_req_data", wr_data, d);
        end
        chk("hit_miss_hold", {31'd0, bus_if.hit_miss}, {31'd0, hit});
        if (!wr) chk("load_data", bus_if.data_to_cpu, exp_data);
        chk("lru_state", {31'd0, dut.lru_store[idx]}, {31'd0, ml[idx]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus_if.phy_addr      = '0;
        bus_if.data_from_cpu = '0;
        bus_if.read_mem      = 1'b0;
        bus_if.write_mem     = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_zero();
        rst    = 1'b0;
        mon_on = 1'b1;

        do_op(1'b0, 1'b1, 32'h0000_1000, 32'd0, 1'b0);
        chk("lit_fill_data", bus_if.data_to_cpu, 32'd64);
        chk("lit_fill_addr", rd_addr, 32'h0000_1000);
        chk("lit_lru0_after_fill", {31'd0, dut.lru_store[0]}, 32'd1);

        do_op(1'b0, 1'b1, 32'h0000_1000, 32'd0, 1'b0);
        chk("lit_hit", {31'd0, bus_if.hit_miss}, 32'd1);
        do_op(1'b0, 1'b1, 32'h0000_1008, 32'd0, 1'b0);
        chk("lit_word2", bus_if.data_to_cpu, 32'h0200_0040);

        do_op(1'b1, 1'b0, 32'h0000_2000, 32'hCAFE_BABE, 1'b0);
        chk("lit_wr_data", wr_data, 32'hCAFE_BABE);

        lat = 5;
        do_op(1'b0, 1'b1, 32'h0004_1000, 32'd0, 1'b1);
        chk("lit_lru0_way1_fill", {31'd0, dut.lru_store[0]}, 32'd0);
        lat = 2;
        do_op(1'b0, 1'b1, 32'h0008_1000, 32'd0, 1'b0);
        chk("lit_lru0_evict", {31'd0, dut.lru_store[0]}, 32'd1);
        chk("lit_evict_data", bus_if.data_to_cpu, 32'h0000_2040);

        do_op(1'b0, 1'b1, 32'h0000_1000, 32'd0, 1'b0);
        do_op(1'b1, 1'b0, 32'h0008_1004, 32'h1234_5678, 1'b0);
        chk("lit_write_hit", {31'd0, bus_if.hit_miss}, 32'd1);
        do_op(1'b0, 1'b1, 32'h0008_1004, 32'd0, 1'b0);
        chk("lit_after_inval", bus_if.data_to_cpu, 32'h0100_2040);
        do_op(1'b1, 1'b1, 32'h0000_3000, 32'h5A5A_0001, 1'b0);

        // Reset while waiting for a line; the memory answer arrives afterwards.
        lat = 4;
        @(negedge clk);
        n_rd = 0; n_wr = 0; n_sw = 0;
        bus_if.phy_addr = 32'h0000_5000;
        bus_if.read_mem = 1'b1;
        @(posedge clk); #1;
        bus_if.read_mem = 1'b0;
        cyc = 0;
        while (n_rd == 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_req_seen", n_rd, 32'd1);
        @(negedge clk);
        rst             = 1'b1;
        bus_if.phy_addr = '0;
        @(posedge clk); #1;
        check_zero();
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_rd = 0; n_wr = 0; n_sw = 0;
        repeat (8) @(negedge clk);
        chk("late_ready_idle", {31'd0, bus_if.ready_stall}, 32'd0);
        chk("late_ready_no_fill", n_sw, 32'd0);
        lat = 3;
        do_op(1'b0, 1'b1, 32'h0000_1000, 32'd0, 1'b0);
        chk("lit_miss_after_rst", {31'd0, bus_if.hit_miss}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
